// File: rtl/multiplier.sv
// Pipelined full-precision multiplier: per-bit partial products summed in a binary adder tree.
// Define MULTIPLIER_SIGNED_EN for two's-complement operands and product; unsigned otherwise.
module multiplier #(
    parameter int unsigned DATA_WIDTH_1 = 8,
    parameter int unsigned DATA_WIDTH_2 = 8,
    parameter int unsigned LATENCY      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid_i,
    input  logic [DATA_WIDTH_1-1:0]              data1_i,
    input  logic [DATA_WIDTH_2-1:0]              data2_i,
    output logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] data_o,
    output logic                                 valid_o
);

    localparam int unsigned PW        = DATA_WIDTH_1 + DATA_WIDTH_2;
    localparam int unsigned NUM_PP    = DATA_WIDTH_2;
    localparam int unsigned LEVELS    = (NUM_PP > 1) ? $clog2(NUM_PP) : 0;
    localparam int unsigned STAGE1    = (LATENCY >= 2) ? 1 : 0;
    localparam int unsigned MID_AVAIL = (LATENCY >= 2) ? (LATENCY - 2) : 0;
    localparam int unsigned MID       = (MID_AVAIL < LEVELS) ? MID_AVAIL : LEVELS;
    // Stages that cannot be placed inside the tree become a delay line ahead of data_o.
    localparam int unsigned TAIL      = LATENCY - 1 - STAGE1 - MID;

`ifdef MULTIPLIER_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    // Number of nodes left after lvl pairwise reductions of the partial products.
    function automatic int unsigned node_count(input int unsigned lvl);
        int unsigned span;
        span = 32'd1 << lvl;
        return (NUM_PP + span - 32'd1) / span;
    endfunction

    // Level 0 is registered when a stage 1 exists; middle stages are spread evenly over the tree.
    function automatic bit level_registered(input int unsigned lvl);
        bit hit;
        hit = 1'b0;
        if (lvl == 0) begin
            hit = (STAGE1 != 0);
        end else begin
            for (int unsigned m = 1; m <= MID; m++) begin
                if (((m * LEVELS) + MID) / (MID + 1) == lvl) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    logic [PW-1:0] op1_ext;

`ifdef MULTIPLIER_SIGNED_EN
    assign op1_ext = PW'($signed(data1_i));
`else
    assign op1_ext = PW'(data1_i);
`endif

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned CNT = node_count(l);

        logic [PW-1:0] node_d [CNT];
        logic [PW-1:0] node   [CNT];

        if (l == 0) begin : g_pp
            // In signed mode the operand-2 sign bit carries negative weight.
            for (genvar j = 0; j < NUM_PP; j++) begin : g_row
                if (SIGNED_MODE && (j == NUM_PP - 1)) begin : g_neg
                    assign node_d[j] = data2_i[j] ? PW'(-(op1_ext << j)) : '0;
                end else begin : g_pos
                    assign node_d[j] = data2_i[j] ? PW'(op1_ext << j) : '0;
                end
            end
        end else begin : g_add
            localparam int unsigned PREV = node_count(l - 1);
            for (genvar i = 0; i < CNT; i++) begin : g_node
                if (2 * i + 1 < PREV) begin : g_pair
                    assign node_d[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
                end else begin : g_pass
                    assign node_d[i] = g_lvl[l-1].node[2*i];
                end
            end
        end

        if (level_registered(l)) begin : g_reg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    node <= '{default: '0};
                end else begin
                    node <= node_d;
                end
            end
        end else begin : g_wire
            assign node = node_d;
        end
    end

    logic [PW-1:0] dly  [TAIL+1];
    logic          vtag [LATENCY];

    // Final tree sum through any leftover stages into the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly <= '{default: '0};
        end else begin
            dly[0] <= g_lvl[LEVELS].node[0];
            for (int unsigned s = 1; s < TAIL + 1; s++) begin
                dly[s] <= dly[s-1];
            end
        end
    end

    // Valid tag travels alongside the data and never gates the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vtag <= '{default: 1'b0};
        end else begin
            vtag[0] <= valid_i;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                vtag[s] <= vtag[s-1];
            end
        end
    end

    assign data_o  = dly[TAIL];
    assign valid_o = vtag[LATENCY-1];

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench: four multiplier instances (8x8 at latency 1/3/4, 12x5 at latency 2).
// Expected products are hand-computed for both unsigned and MULTIPLIER_SIGNED_EN builds.
module tb_multiplier;

    typedef struct {
        logic [16:0] data;
        int unsigned due;
    } exp_t;

`ifdef MULTIPLIER_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        v8;
    logic        va;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [11:0] da1;
    logic [4:0]  da2;
    logic [15:0] q_l1;
    logic [15:0] q_l3;
    logic [15:0] q_l4;
    logic [16:0] q_a;
    logic        vo   [4];
    logic [16:0] dout [4];

    exp_t        sbq [4][$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          chk_zero;
    bit          final_chk;
    bit          done;

    multiplier #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(8), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .valid_i(v8), .data1_i(d1), .data2_i(d2),
        .data_o(q_l1), .valid_o(vo[0]));

    multiplier #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(8), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .valid_i(v8), .data1_i(d1), .data2_i(d2),
        .data_o(q_l3), .valid_o(vo[1]));

    multiplier #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(8), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .valid_i(v8), .data1_i(d1), .data2_i(d2),
        .data_o(q_l4), .valid_o(vo[2]));

    multiplier #(.DATA_WIDTH_1(12), .DATA_WIDTH_2(5), .LATENCY(2)) u_asym (
        .clk(clk), .rst_n(rst_n), .valid_i(va), .data1_i(da1), .data2_i(da2),
        .data_o(q_a), .valid_o(vo[3]));

    assign dout[0] = {1'b0, q_l1};
    assign dout[1] = {1'b0, q_l3};
    assign dout[2] = {1'b0, q_l4};
    assign dout[3] = q_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    // Monitor: pops one expectation per valid result and checks value and arrival cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int d = 0; d < 4; d++) begin
            if (chk_zero) begin
                n_chk++;
                if (dout[d] === 17'd0 && vo[d] === 1'b0) n_pass++;
                else $display("FAIL reset_zero dut%0d cyc %0d: got data=%0d valid=%b, want data=0 valid=0",
                              d, cyc, dout[d], vo[d]);
            end else if (vo[d] === 1'b1) begin
                n_chk++;
                if (sbq[d].size() == 0) begin
                    $display("FAIL stray_result dut%0d cyc %0d: got data=%0d valid=1, want no result",
                             d, cyc, dout[d]);
                end else begin
                    e = sbq[d].pop_front();
                    if (dout[d] === e.data && cyc == e.due) n_pass++;
                    else $display("FAIL product dut%0d: got data=%0d at cyc %0d, want data=%0d at cyc %0d",
                                  d, dout[d], cyc, e.data, e.due);
                end
            end
        end
        if (final_chk && !done) begin
            for (int d = 0; d < 4; d++) begin
                n_chk++;
                if (sbq[d].size() == 0) n_pass++;
                else $display("FAIL missing_results dut%0d: got %0d undelivered, want 0", d, sbq[d].size());
            end
            done = 1'b1;
        end
    end

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic v,
                          input logic [15:0] eu, input logic [15:0] es);
        exp_t e;
        d1 = a; d2 = b; v8 = v; va = 1'b0;
        if (v) begin
            for (int d = 0; d < 3; d++) begin
                e.data = {1'b0, (SGN ? es : eu)};
                e.due  = cyc + lat_of(d);
                sbq[d].push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic drivea(input logic [11:0] a, input logic [4:0] b, input logic v,
                          input logic [16:0] eu, input logic [16:0] es);
        exp_t e;
        da1 = a; da2 = b; va = v; v8 = 1'b0;
        if (v) begin
            e.data = SGN ? es : eu;
            e.due  = cyc + lat_of(3);
            sbq[3].push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; chk_zero = 1'b1; final_chk = 1'b0; done = 1'b0;
        v8 = 1'b0; va = 1'b0; d1 = '0; d2 = '0; da1 = '0; da2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; chk_zero = 1'b0;

        // Operand pairs held for two cycles each.
        repeat (2) drive8(8'd34, 8'd22, 1'b1, 16'd748,  16'd748);
        repeat (2) drive8(8'd34, 8'd9,  1'b1, 16'd306,  16'd306);
        repeat (2) drive8(8'd9,  8'd9,  1'b1, 16'd81,   16'd81);
        repeat (2) drive8(8'd99, 8'd9,  1'b1, 16'd891,  16'd891);
        repeat (2) drive8(8'd99, 8'd99, 1'b1, 16'd9801, 16'd9801);

        // Edge operands; signed column reads the bytes as two's complement.
        drive8(8'd0,   8'd200, 1'b1, 16'd0,     16'd0);
        drive8(8'd255, 8'd255, 1'b1, 16'd65025, 16'd1);
        drive8(8'd1,   8'd255, 1'b1, 16'd255,   16'hFFFF);
        drive8(8'd128, 8'd128, 1'b1, 16'd16384, 16'h4000);
        drive8(8'd255, 8'd1,   1'b1, 16'd255,   16'hFFFF);
        drive8(8'd127, 8'd128, 1'b1, 16'd16256, 16'hC080);

        // Back-to-back stream with valid toggling.
        drive8(8'd3,   8'd5,   1'b1, 16'd15,    16'd15);
        drive8(8'd17,  8'd19,  1'b0, 16'd323,   16'd323);
        drive8(8'd200, 8'd3,   1'b1, 16'd600,   16'd65368);
        drive8(8'd128, 8'd2,   1'b0, 16'd256,   16'd65280);
        drive8(8'd15,  8'd15,  1'b1, 16'd225,   16'd225);
        drive8(8'd250, 8'd4,   1'b1, 16'd1000,  16'd65512);
        drive8(8'd7,   8'd11,  1'b0, 16'd77,    16'd77);
        drive8(8'd100, 8'd100, 1'b1, 16'd10000, 16'd10000);

        // Asymmetric 12x5 instance.
        drivea(12'd4095, 5'd31, 1'b1, 17'd126945, 17'd1);
        drivea(12'd0,    5'd31, 1'b1, 17'd0,      17'd0);
        drivea(12'd2048, 5'd16, 1'b0, 17'd32768,  17'd32768);
        drivea(12'd2048, 5'd16, 1'b1, 17'd32768,  17'd32768);
        drivea(12'd100,  5'd3,  1'b1, 17'd300,    17'd300);
        drivea(12'd1,    5'd31, 1'b1, 17'd31,     17'd131071);
        drivea(12'd4095, 5'd1,  1'b1, 17'd4095,   17'd131071);

        // Reset pulse with results in flight; those results must never appear.
        drive8(8'd12, 8'd12, 1'b1, 16'd144, 16'd144);
        drive8(8'd13, 8'd13, 1'b1, 16'd169, 16'd169);
        rst_n = 1'b0; chk_zero = 1'b1; d1 = 8'd14; d2 = 8'd14; v8 = 1'b1;
        for (int d = 0; d < 4; d++) sbq[d].delete();
        @(negedge clk);
        rst_n = 1'b1; chk_zero = 1'b0;
        drive8(8'd2, 8'd3, 1'b1, 16'd6,  16'd6);
        drive8(8'd4, 8'd5, 1'b1, 16'd20, 16'd20);

        repeat (6) drive8(8'd0, 8'd0, 1'b0, 16'd0, 16'd0);
        final_chk = 1'b1;
        for (int i = 0; i < 5 && !done; i++) @(negedge clk);
        if (!done) begin
            $display("FAIL final_check timeout: got done=0, want done=1");
            $fatal(1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
